fb_port_arbiter: RTL and testbench
==================================

// Module: fb_port_arbiter
// PURPOSE
//  Shares the single-port frame-buffer RAM (X_PIXEL_MEM x Y_PIXEL_MEM raw_pixel_t) between the VGA scan-out reader and the renderer.
//  Scan-out reads take absolute priority and never stall. Renderer writes (render_pixel_t) are queued in a small FIFO and drained on
//  free cycles. Read data is re-joined with its vga_ctrl_t and emitted as mem_pixel_t for the colour-lookup stage.
// PARAMETERS
//  FIFO_DEPTH  8                                        renderer write queue entries (power of 2, >=2)
//  ADDR_W      $clog2(X_PIXEL_MEM*Y_PIXEL_MEM) (=15)    frame-buffer word address width
// PORTS
//  clk          in   1                      system clock
//  rst_n        in   1                      async active-low reset
//  vga_ctrl_in  in   $bits(vga_ctrl_t)      timing/ctrl of current scan cycle
//  rd_en        in   1                      scan-out wants a read this cycle
//  rd_addr      in   ADDR_W                 read word address
//  mem_out      out  $bits(mem_pixel_t)     ctrl + read pixel, 2-cycle latency
//  wr_valid     in   1                      renderer write request
//  wr_ready     out  1                      FIFO can accept (registered, = !full)
//  wr_pix       in   $bits(render_pixel_t)  renderer x, y, pixel
//  fb_addr      out  ADDR_W                 RAM address
//  fb_we        out  1                      RAM write enable
//  fb_wdata     out  BITSPERPIXEL           RAM write data
//  fb_rdata     in   BITSPERPIXEL           RAM read data, valid 1 cycle after address
//  fifo_level   out  $clog2(FIFO_DEPTH)+1   current FIFO occupancy
//  drop_cnt     out  16                     out-of-range writes discarded, saturating
// BEHAVIOUR
//  Reset (async assert, sync release): mem_out=mem_pixel_dv (hs=1,vs=1,active=0,pixel=0), fb_we=0, fifo_level=0,
//   drop_cnt=0, wr_ready=0 while in reset, 1 on first cycle after release. Reset mid-operation flushes FIFO and pipeline.
//  Write accept: handshake on wr_valid & wr_ready. Address = pixel_y*X_PIXEL_MEM + pixel_x, computed at push.
//   If pixel_x>=X_PIXEL_MEM or pixel_y>=Y_PIXEL_MEM: still accepted, not queued, drop_cnt+1 (hold at 16'hFFFF).
//  RAM port mux, combinational from rd_en and FIFO head:
//   rd_en=1              -> fb_addr=rd_addr, fb_we=0 (no pop)
//   rd_en=0, FIFO nonempty -> fb_addr=head addr, fb_wdata=head data, fb_we=1, pop
//   rd_en=0, FIFO empty  -> fb_we=0, fb_addr=0
//  Min write latency: push in cycle N -> earliest fb_we in N+1 (no FIFO bypass). Writes hit RAM in accept order.
//  Push and pop same cycle: level unchanged. Full: wr_ready=0 next cycle; no push-on-pop when full.
//  Read path: stage1 registers vga_ctrl_in and rd_en; stage2 registers mem_out.ctrl=stage1 ctrl,
//   mem_out.pixel = stage1 rd_en ? fb_rdata : 0. Ctrl always advances every cycle regardless of rd_en.
//  Read of an address with a queued write returns old RAM content (no forwarding); renderer owns coherency.
//  Pointers wrap modulo FIFO_DEPTH; fifo_level in 0..FIFO_DEPTH.
// TESTING
//  1. Reset asserted mid-drain with level=5 -> mem_out==mem_pixel_dv, fb_we=0, level=0; wr_ready=1 one cycle after release.
//  2. RAM[5]=8'hA5, rd_en=1 rd_addr=5 with ctrl{x=10,y=3,active=1} in cycle N -> mem_out carries that ctrl and pixel 8'hA5 in N+2.
//  3. rd_en=0, push {x=3,y=2,pixel=8'h7E} in N -> N+1: fb_we=1, fb_addr=197, fb_wdata=8'h7E, level back to 0.
//  4. rd_en=1 for 20 cycles, renderer offers 10 writes -> 8 accepted then wr_ready=0, fb_we=0 throughout;
//     rd_en drops -> 8 back-to-back writes in order, then remaining 2 accepted and written.
//  5. Writes {x=97,y=0},{x=0,y=257} -> no fb_we, drop_cnt=2; force 70000 drops -> drop_cnt=16'hFFFF.
//  6. Corner write {x=96,y=256} -> fb_addr=24928; interleave rd_en 1/0 each cycle -> writes only on rd_en=0 cycles.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
//   Arbitrates the single-port frame-buffer RAM between the VGA scan-out
//   reader and the renderer. Scan-out reads always win. Renderer writes are
//   queued in a small FIFO and drained on cycles without a read. Read data is
//   re-joined with its scan control two cycles later as mem_pixel_t.
// Ports
//   clk, rst_n           clock, async active-low reset
//   vga_ctrl_in          scan timing/control of the current cycle
//   rd_en, rd_addr       scan-out read request and word address
//   mem_out              ctrl + read pixel, 2-cycle latency
//   wr_valid, wr_ready   renderer write handshake (wr_ready registered)
//   wr_pix               renderer x, y, pixel
//   fb_addr, fb_we,
//   fb_wdata, fb_rdata   RAM port (read data 1 cycle after address)
//   fifo_level           write queue occupancy
//   drop_cnt             saturating count of out-of-range writes

package fb_pkg;
  localparam int unsigned X_PIXEL_MEM  = 97;
  localparam int unsigned Y_PIXEL_MEM  = 257;
  localparam int unsigned BITSPERPIXEL = 8;

  typedef logic [BITSPERPIXEL-1:0] raw_pixel_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       active;
  } vga_ctrl_t;

  typedef struct packed {
    vga_ctrl_t  ctrl;
    raw_pixel_t pixel;
  } mem_pixel_t;

  typedef struct packed {
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    raw_pixel_t pixel;
  } render_pixel_t;

  localparam mem_pixel_t mem_pixel_dv = '{
    ctrl:  '{x: '0, y: '0, hs: 1'b1, vs: 1'b1, active: 1'b0},
    pixel: '0
  };
endpackage

module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = $clog2(X_PIXEL_MEM * Y_PIXEL_MEM)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  vga_ctrl_t                     vga_ctrl_in,
  input  logic                          rd_en,
  input  logic [ADDR_W-1:0]             rd_addr,
  output mem_pixel_t                    mem_out,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  render_pixel_t                 wr_pix,
  output logic [ADDR_W-1:0]             fb_addr,
  output logic                          fb_we,
  output logic [BITSPERPIXEL-1:0]       fb_wdata,
  input  logic [BITSPERPIXEL-1:0]       fb_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  raw_pixel_t        q_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [LVL_W-1:0]  level_next;

  logic              in_range, accept, push, drop, pop;
  logic [ADDR_W-1:0] push_addr;

  vga_ctrl_t         ctrl_s1;
  logic              rd_s1;

  assign in_range  = (32'(wr_pix.pixel_x) < X_PIXEL_MEM) &&
                     (32'(wr_pix.pixel_y) < Y_PIXEL_MEM);
  assign push_addr = ADDR_W'(32'(wr_pix.pixel_y) * X_PIXEL_MEM + 32'(wr_pix.pixel_x));

  // Out-of-range writes complete the handshake but never enter the queue.
  assign accept = wr_valid & wr_ready;
  assign push   = accept & in_range;
  assign drop   = accept & ~in_range;
  assign pop    = ~rd_en & (fifo_level != '0);

  assign level_next = fifo_level + LVL_W'(push) - LVL_W'(pop);

  always_comb begin
    fb_we    = pop;
    fb_addr  = '0;
    fb_wdata = '0;
    if (rd_en) begin
      fb_addr = rd_addr;
    end else if (pop) begin
      fb_addr  = q_addr[rd_ptr];
      fb_wdata = q_data[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= push_addr;
      q_data[wr_ptr] <= wr_pix.pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      wr_ready   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level <= level_next;
      // Registered from next occupancy so it always equals !full of the
      // current level; a full queue never accepts even while popping.
      wr_ready   <= (level_next != LVL_W'(FIFO_DEPTH));
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_s1 <= mem_pixel_dv.ctrl;
      rd_s1   <= 1'b0;
      mem_out <= mem_pixel_dv;
    end else begin
      ctrl_s1       <= vga_ctrl_in;
      rd_s1         <= rd_en;
      mem_out.ctrl  <= ctrl_s1;
      mem_out.pixel <= rd_s1 ? fb_rdata : '0;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter
//   Scoreboard bench for fb_port_arbiter. Stimulus runs in one process; a
//   monitor on the falling edge keeps a reference queue of accepted writes,
//   a reference picture of RAM contents and a queue of expected scan-out
//   words, and compares every DUT output against them.
module tb_fb_port_arbiter;
  import fb_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  vga_ctrl_t     vga_ctrl_in;
  logic          rd_en;
  logic [14:0]   rd_addr;
  mem_pixel_t    mem_out;
  logic          wr_valid;
  logic          wr_ready;
  render_pixel_t wr_pix;
  logic [14:0]   fb_addr;
  logic          fb_we;
  logic [7:0]    fb_wdata;
  logic [7:0]    fb_rdata;
  logic [3:0]    fifo_level;
  logic [15:0]   drop_cnt;

  always #5 clk = ~clk;

  fb_port_arbiter #(.FIFO_DEPTH(8), .ADDR_W(15)) dut (
    .clk(clk), .rst_n(rst_n), .vga_ctrl_in(vga_ctrl_in), .rd_en(rd_en),
    .rd_addr(rd_addr), .mem_out(mem_out), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_pix(wr_pix), .fb_addr(fb_addr), .fb_we(fb_we),
    .fb_wdata(fb_wdata), .fb_rdata(fb_rdata), .fifo_level(fifo_level),
    .drop_cnt(drop_cnt)
  );

  // Physical RAM seen by the DUT.
  logic [7:0] ram [32768];
  always @(posedge clk) begin
    if (fb_we) ram[fb_addr] <= fb_wdata;
    fb_rdata <= ram[fb_addr];
  end

  typedef struct {
    logic [14:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic [7:0] ref_mem [32768];
  wr_t        wq[$];
  mem_pixel_t rq[$];
  int         drop_exp;
  int         since_rel;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor / reference model.
  always @(negedge clk) begin : monitor
    bit          exp_ready, exp_we;
    logic [14:0] exp_addr;
    wr_t         w;
    mem_pixel_t  e;
    if (!rst_n) begin
      chk("rst_mem_out", 64'(mem_out), 64'(mem_pixel_dv));
      chk("rst_fb_we", 64'(fb_we), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_wr_ready", 64'(wr_ready), 64'd0);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      wq.delete();
      rq.delete();
      rq.push_back(mem_pixel_dv);
      rq.push_back(mem_pixel_dv);
      drop_exp  = 0;
      since_rel = 0;
    end else begin
      exp_ready = (since_rel >= 1) && (wq.size() < 8);
      chk("level", 64'(fifo_level), 64'(wq.size()));
      chk("wr_ready", 64'(wr_ready), 64'(exp_ready));
      chk("drop_cnt", 64'(drop_cnt), 64'(drop_exp));
      // Queue contents before this cycle's push: no same-cycle bypass.
      exp_we = !rd_en && (wq.size() > 0);
      chk("fb_we", 64'(fb_we), 64'(exp_we));
      if (rd_en)       exp_addr = rd_addr;
      else if (exp_we) exp_addr = wq[0].addr;
      else             exp_addr = '0;
      chk("fb_addr", 64'(fb_addr), 64'(exp_addr));
      if (exp_we) begin
        w = wq.pop_front();
        chk("fb_wdata", 64'(fb_wdata), 64'(w.data));
        ref_mem[w.addr] = w.data;
      end
      e.ctrl  = vga_ctrl_in;
      e.pixel = rd_en ? ref_mem[rd_addr] : 8'h00;
      rq.push_back(e);
      e = rq.pop_front();
      chk("mem_out", 64'(mem_out), 64'(e));
      if (wr_valid && exp_ready) begin
        if (int'(wr_pix.pixel_x) < 97 && int'(wr_pix.pixel_y) < 257) begin
          w.addr = 15'(int'(wr_pix.pixel_y) * 97 + int'(wr_pix.pixel_x));
          w.data = wr_pix.pixel;
          wq.push_back(w);
        end else if (drop_exp < 65535) begin
          drop_exp++;
        end
      end
      if (since_rel < 2) since_rel++;
    end
  end

  // One clock of stimulus; acc reports whether the offered write was taken.
  task automatic step(output bit acc);
    @(negedge clk);
    acc = wr_valid && wr_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic stepn(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic rand_ctrl();
    vga_ctrl_in = '{x: 10'($urandom_range(0, 799)), y: 10'($urandom_range(0, 524)),
                    hs: 1'($urandom), vs: 1'($urandom), active: 1'($urandom)};
  endtask

  function automatic render_pixel_t mkpix(input int x, input int y, input int p);
    render_pixel_t r;
    r.pixel_x = 10'(x);
    r.pixel_y = 10'(y);
    r.pixel   = 8'(p);
    return r;
  endfunction

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit            acc;
    int            i;
    render_pixel_t items [10];

    for (int a = 0; a < 32768; a++) begin
      ram[a]     = 8'($urandom);
      ref_mem[a] = ram[a];
    end
    ram[5] = 8'hA5;
    ref_mem[5] = 8'hA5;

    rst_n = 1'b0; rd_en = 1'b0; rd_addr = '0; wr_valid = 1'b0;
    wr_pix = '0; vga_ctrl_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    stepn(2);

    // Read of a preloaded word carries its ctrl through two stages.
    rd_en = 1'b1; rd_addr = 15'd5;
    vga_ctrl_in = '{x: 10'd10, y: 10'd3, hs: 1'b1, vs: 1'b1, active: 1'b1};
    step(acc);
    rd_en = 1'b0; rand_ctrl();
    stepn(3);

    // Single write drains the cycle after it is queued.
    wr_valid = 1'b1; wr_pix = mkpix(3, 2, 8'h7E);
    step(acc);
    chk("t3_accept", 64'(acc), 64'd1);
    wr_valid = 1'b0;
    stepn(3);

    // Continuous reads starve the queue: it fills, then drains in order.
    for (int k = 0; k < 10; k++) items[k] = mkpix($urandom_range(0, 96), $urandom_range(0, 256), $urandom);
    i = 0;
    for (int c = 0; c < 20; c++) begin
      rd_en = 1'b1; rd_addr = 15'($urandom_range(0, 24928)); rand_ctrl();
      wr_valid = (i < 10);
      if (i < 10) wr_pix = items[i];
      step(acc);
      if (acc) i++;
    end
    chk("t4_accepted_while_reading", 64'(i), 64'd8);
    rd_en = 1'b0;
    for (int c = 0; c < 30 && i < 10; c++) begin
      wr_valid = 1'b1; wr_pix = items[i]; rand_ctrl();
      step(acc);
      if (acc) i++;
    end
    chk("t4_all_accepted", 64'(i), 64'd10);
    wr_valid = 1'b0;
    stepn(12);

    // Out-of-range writes just bump the counter, which saturates.
    wr_valid = 1'b1; wr_pix = mkpix(97, 0, 8'h11);
    step(acc);
    wr_pix = mkpix(0, 257, 8'h22);
    step(acc);
    wr_valid = 1'b0;
    stepn(2);
    chk("t5_drop_two", 64'(drop_cnt), 64'd2);
    wr_valid = 1'b1; wr_pix = mkpix(200, 300, 8'h33);
    for (int c = 0; c < 65540; c++) begin
      rd_en = 1'($urandom); rd_addr = 15'($urandom_range(0, 24928)); rand_ctrl();
      step(acc);
    end
    wr_valid = 1'b0; rd_en = 1'b0;
    stepn(2);
    chk("t5_drop_saturated", 64'(drop_cnt), 64'hFFFF);

    // Corner pixel, then alternating reads and writes.
    wr_valid = 1'b1; wr_pix = mkpix(96, 256, 8'h5A);
    step(acc);
    for (int c = 0; c < 40; c++) begin
      rd_en = c[0]; rd_addr = 15'($urandom_range(0, 24928)); rand_ctrl();
      wr_valid = 1'($urandom);
      wr_pix = mkpix($urandom_range(0, 96), $urandom_range(0, 256), $urandom);
      step(acc);
    end
    wr_valid = 1'b0; rd_en = 1'b0;
    stepn(12);

    // Reset in the middle of a drain with five entries queued.
    rd_en = 1'b1;
    for (int c = 0; c < 7; c++) begin
      wr_valid = 1'b1; wr_pix = mkpix($urandom_range(0, 96), $urandom_range(0, 256), $urandom);
      step(acc);
    end
    wr_valid = 1'b0; rd_en = 1'b0;
    stepn(2);
    chk("t1_level_before_reset", 64'(fifo_level), 64'd5);
    rst_n = 1'b0;
    stepn(2);
    rst_n = 1'b1;
    stepn(3);

    // Random traffic, including some out-of-range writes.
    for (int c = 0; c < 3000; c++) begin
      rd_en = ($urandom_range(0, 99) < 55); rd_addr = 15'($urandom_range(0, 24928)); rand_ctrl();
      wr_valid = 1'($urandom);
      wr_pix = mkpix($urandom_range(0, 100), $urandom_range(0, 260), $urandom);
      step(acc);
    end
    wr_valid = 1'b0; rd_en = 1'b0;
    stepn(12);
    chk("final_queue_empty", 64'(wq.size()), 64'd0);
    chk("final_level", 64'(fifo_level), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
